// File: rtl/mudv_pkg.sv
// mudv_pkg: mdop encodings, FSM states and default latencies shared by mudv, decoder and stall logic
package mudv_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdop_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;
  function automatic logic is_md(logic [2:0] op);
    return op <= MD_DIVU;
  endfunction
  function automatic logic is_div(logic [2:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/mudv_if.sv
// mudv_if: E-stage request and HI/LO result bundle of the multiply/divide unit
interface mudv_if;
  logic start;
  logic [2:0] mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic occupied;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, mdop, a, b, input occupied, hi, lo);
  modport slave (input start, mdop, a, b, output occupied, hi, lo);
endinterface

// File: rtl/mudv_arith.sv
// mudv_arith: combinational 64-bit {hi,lo} result for the latched multiply/divide operation
module mudv_arith
  import mudv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [63:0] res,
  output logic        dz
);
  logic signed [63:0] sprod;
  logic [63:0] uprod;
  logic signed [31:0] sdiv, srem;
  logic [31:0] sq, sr, uq, ur;
  logic ovf;
  assign dz = b == '0;
  assign ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};
  // signed ops live on their own wires so an unsigned ternary arm cannot strip their signedness
  assign sdiv = $signed(a) / $signed(b);
  assign srem = $signed(a) % $signed(b);
  assign sq = dz ? '0 : ovf ? 32'h8000_0000 : sdiv;
  assign sr = (dz || ovf) ? '0 : srem;
  assign uq = dz ? '0 : a / b;
  assign ur = dz ? '0 : a % b;
  assign res = op == MD_MULT  ? sprod :
               op == MD_MULTU ? uprod :
               op == MD_DIV   ? {sr, sq} :
               op == MD_DIVU  ? {ur, uq} : '0;
endmodule

// File: rtl/mudv.sv
// mudv: multi-cycle multiply/divide unit with HI/LO registers and IDLE/BUSY control
module mudv
  import mudv_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input logic clk,
  input logic reset,
  mudv_if.slave bus
);
  localparam int CW = $clog2((MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC) + 1);
  state_e state, state_n;
  logic [CW-1:0] count, count_n;
  logic [31:0] a_q, b_q, a_n, b_n, hi, lo, hi_n, lo_n;
  logic [2:0] op_q, op_n;
  logic [63:0] res;
  logic dz, go;
  mudv_arith u_arith (.a(a_q), .b(b_q), .op(op_q), .res(res), .dz(dz));
  assign go = bus.start && is_md(bus.mdop);
  assign bus.occupied = go || state == BUSY;
  assign bus.hi = hi;
  assign bus.lo = lo;
  always_comb begin
    state_n = state;
    count_n = count;
    a_n = a_q;
    b_n = b_q;
    op_n = op_q;
    hi_n = hi;
    lo_n = lo;
    if (state == IDLE) begin
      if (go) begin
        state_n = BUSY;
        a_n = bus.a;
        b_n = bus.b;
        op_n = bus.mdop;
        count_n = is_div(bus.mdop) ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (bus.start && bus.mdop == MD_MTHI) hi_n = bus.a;
      else if (bus.start && bus.mdop == MD_MTLO) lo_n = bus.a;
    end else begin
      count_n = count - 1'b1;
      // HI/LO only ever change at the final busy edge; a zero divisor leaves them untouched
      if (count == CW'(1)) begin
        state_n = IDLE;
        if (!(is_div(op_q) && dz)) {hi_n, lo_n} = res;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      a_q <= a_n;
      b_q <= b_n;
      op_q <= op_n;
      hi <= hi_n;
      lo <= lo_n;
    end
  end
endmodule

// File: tb/tb_mudv.sv
// tb_mudv: directed vector table, reset abort sequence and randomized ops against an arithmetic model
module tb_mudv;
  import mudv_pkg::*;
  logic clk = 1'b0;
  logic reset;
  mudv_if bus();
  mudv dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[13];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int cycles(logic [2:0] op);
    return op < 3'd2 ? 5 : op < 3'd4 ? 10 : 0;
  endfunction
  function automatic logic [63:0] ref_model(logic [2:0] op, logic [31:0] a, b, hi, lo);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: return b == 0 ? {hi, lo} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return b == 0 ? {hi, lo} : {a % b, a / b};
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction
  task automatic run_op(string name, logic [2:0] op, logic [31:0] a, b, exp_hi, exp_lo);
    int n = cycles(op);
    bus.start = 1'b1;
    bus.mdop = op;
    bus.a = a;
    bus.b = b;
    #1 check({name, " occ_start"}, 32'(bus.occupied), 32'(n > 0));
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.mdop = 3'($urandom);
      bus.a = $urandom;
      bus.b = $urandom;
      #1;
      check({name, " occ_busy"}, 32'(bus.occupied), 32'd1);
      check({name, " hi_hold"}, bus.hi, cur_hi);
      check({name, " lo_hold"}, bus.lo, cur_lo);
      @(negedge clk);
    end
    bus.start = 1'b0;
    #1;
    check({name, " occ_idle"}, 32'(bus.occupied), 32'd0);
    check({name, " hi"}, bus.hi, exp_hi);
    check({name, " lo"}, bus.lo, exp_lo);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    logic [63:0] e;
    vecs = '{
      '{3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA},
      '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
      '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{3'd4, 32'h11, 32'd0, 32'h11, 32'hFFFF_FFFD},
      '{3'd5, 32'h22, 32'd0, 32'h11, 32'h22},
      '{3'd3, 32'd7, 32'd0, 32'h11, 32'h22},
      '{3'd4, 32'h1234, 32'd9, 32'h1234, 32'h22},
      '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000},
      '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14},
      '{3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD},
      '{3'd6, 32'd5, 32'd5, 32'd1, 32'hFFFF_FFFD},
      '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0},
      '{3'd2, 32'd0, 32'd0, 32'd1, 32'd0}
    };
    bus.start = 1'b0;
    bus.mdop = '0;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset occ", 32'(bus.occupied), 32'd0);
    bus.start = 1'b1;
    #1 check("reset occ_start", 32'(bus.occupied), 32'd1);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    bus.start = 1'b1;
    bus.mdop = MD_MULT;
    bus.a = 32'd5;
    bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    check("abort occ", 32'(bus.occupied), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort nocommit hi", bus.hi, 32'd0);
      check("abort nocommit lo", bus.lo, 32'd0);
      check("abort nocommit occ", 32'(bus.occupied), 32'd0);
    end
    cur_hi = '0;
    cur_lo = '0;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 5) == 0 ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      e = ref_model(op, a, b, cur_hi, cur_lo);
      run_op($sformatf("rnd%0d op%0d", k, op), op, a, b, e[63:32], e[31:0]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
